// File: rtl/uart_tx_driver_pkg.sv
// uart_tx_driver_pkg: shared FSM states, register addresses and status-word layout for the UART transmitter.
//  Status word bits: [3] overflow, [2] busy, [1] empty, [0] full.
`timescale 1ns/1ps
package uart_tx_driver_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_STAT = 2'd1;
   localparam int ST_FULL  = 0;
   localparam int ST_EMPTY = 1;
   localparam int ST_BUSY  = 2;
   localparam int ST_OVF   = 3;
   function automatic logic [15:0] status_word(input logic ovf, input logic bsy, input logic emp, input logic ful);
      status_word = '0;
      status_word[ST_OVF] = ovf;
      status_word[ST_BUSY] = bsy;
      status_word[ST_EMPTY] = emp;
      status_word[ST_FULL] = ful;
   endfunction
endpackage

// File: rtl/uart_tx_driver_fifo.sv
// uart_tx_driver_fifo: byte FIFO feeding the UART serialiser.
//  clk, rst_n (async, active-low); push/din write a byte; pop advances the read side;
//  flush drops all queued bytes and wins over a same-cycle pop; dout shows the head byte;
//  full/empty come from comparing wrap-bit pointers.
`timescale 1ns/1ps
module uart_tx_driver_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic       pop,
   input  logic       flush,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);
   localparam int AW = $clog2(DEPTH);
   logic [AW:0] wr_ptr, rd_ptr;
   logic [7:0] mem [DEPTH];
   logic do_pop, do_push;
   assign empty = wr_ptr == rd_ptr;
   assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout = mem[rd_ptr[AW-1:0]];
   assign do_pop = pop && !empty && !flush;
   // a full FIFO still accepts a byte when the head leaves in the same cycle
   assign do_push = push && (!full || do_pop);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr <= flush ? wr_ptr : do_pop ? rd_ptr + 1'b1 : rd_ptr;
      end
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/uart_tx_driver.sv
// uart_tx_driver: memory-mapped 8N1 UART transmitter (CPU writes bytes to a FIFO, polls status).
//  iCpuClock/iCpuResetN: clock and async active-low reset.
//  iDoUartWrite/iDoUartRead/iUartAddress/iUartDataToWrite: CPU access (addr 0 data, addr 1 status/flush).
//  oUartDataRead: read data, 16'h0 unless a status read is in progress.
//  oUartToPc: registered serial line, idle high.  oTxBusy: frame in flight or bytes queued.
`timescale 1ns/1ps
module uart_tx_driver
   import uart_tx_driver_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 23_000_000,
   parameter int BAUD        = 115_200,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic        iCpuClock,
   input  logic        iCpuResetN,
   input  logic        iDoUartWrite,
   input  logic        iDoUartRead,
   input  logic [1:0]  iUartAddress,
   input  logic [15:0] iUartDataToWrite,
   output logic [15:0] oUartDataRead,
   output logic        oUartToPc,
   output logic        oTxBusy
);
   localparam int DIV = CLK_FREQ_HZ / BAUD;
   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   tx_state_t state;
   logic [CW-1:0] baud_cnt;
   logic [2:0] bit_cnt;
   logic [7:0] shift, fifo_dout;
   logic line, overflow, fifo_full, fifo_empty;
   logic wr_data, rd_stat, flush, baud_last, pop, busy, unused_wdata;
   assign wr_data = iDoUartWrite && iUartAddress == ADDR_DATA;
   assign rd_stat = iDoUartRead && iUartAddress == ADDR_STAT;
   assign flush = iDoUartWrite && iUartAddress == ADDR_STAT && iUartDataToWrite[0];
   assign baud_last = baud_cnt == CNT_LAST;
   // a flush in the same cycle cancels the pop, so the FSM must not start a frame either
   assign pop = !fifo_empty && !flush && (state == IDLE || (state == STOP && baud_last));
   assign busy = state != IDLE || !fifo_empty;
   assign oTxBusy = busy;
   assign oUartToPc = line;
   assign oUartDataRead = rd_stat ? status_word(overflow, busy, fifo_empty, fifo_full) : 16'h0;
   assign unused_wdata = ^iUartDataToWrite[15:8];
   uart_tx_driver_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(iCpuClock),
      .rst_n(iCpuResetN),
      .push(wr_data),
      .pop(pop),
      .flush(flush),
      .din(iUartDataToWrite[7:0]),
      .dout(fifo_dout),
      .full(fifo_full),
      .empty(fifo_empty)
   );
   // the line register follows the state one cycle late, so every bit keeps exactly DIV cycles
   always_ff @(posedge iCpuClock or negedge iCpuResetN)
      if (!iCpuResetN) begin
         state <= IDLE;
         baud_cnt <= '0;
         bit_cnt <= '0;
         shift <= '0;
         line <= 1'b1;
      end else begin
         line <= state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
         baud_cnt <= (state == IDLE || baud_last) ? '0 : baud_cnt + 1'b1;
         case (state)
            IDLE:
               if (pop) begin
                  shift <= fifo_dout;
                  state <= START;
               end
            START:
               if (baud_last) begin
                  bit_cnt <= '0;
                  state <= DATA;
               end
            DATA:
               if (baud_last) begin
                  shift <= shift >> 1;
                  bit_cnt <= bit_cnt + 1'b1;
                  state <= bit_cnt == 3'd7 ? STOP : DATA;
               end
            STOP:
               if (baud_last) begin
                  shift <= pop ? fifo_dout : shift;
                  state <= pop ? START : IDLE;
               end
         endcase
      end
   // a drop in the same cycle as a clearing status read wins
   always_ff @(posedge iCpuClock or negedge iCpuResetN)
      if (!iCpuResetN) overflow <= 1'b0;
      else overflow <= (wr_data && fifo_full && !pop) || (overflow && !rd_stat);
endmodule

// File: tb/tb_uart_tx_driver.sv
`timescale 1ns/1ps
module tb_uart_tx_driver;
   localparam int FRAME = 100;
   logic clk = 0, rst_n = 0, wr = 0, rd = 0;
   logic [1:0] addr = 0;
   logic [15:0] wdata = 0, rdata;
   logic line, busy;
   typedef struct { int pop; logic [7:0] data; } exp_t;
   exp_t q[$];
   int hist[$];
   int cyc = 0, total = 0, bad = 0, last_pop = -1000;
   bit ovf_m = 0, mon_en = 1;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   uart_tx_driver #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(8)) dut (
      .iCpuClock(clk), .iCpuResetN(rst_n), .iDoUartWrite(wr), .iDoUartRead(rd),
      .iUartAddress(addr), .iUartDataToWrite(wdata), .oUartDataRead(rdata),
      .oUartToPc(line), .oTxBusy(busy));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // bytes still queued after edge e: those whose frame starts later
   function automatic int occ(input int e);
      int n = 0;
      foreach (q[i]) if (q[i].pop > e) n++;
      return n;
   endfunction

   // a frame whose head left the FIFO at edge p keeps the transmitter busy for edges p..p+99
   function automatic bit in_frame(input int e);
      foreach (hist[i]) if (hist[i] <= e && e < hist[i] + FRAME) return 1;
      return 0;
   endfunction

   function automatic logic [15:0] stat_m(input int e);
      int n = occ(e);
      logic [15:0] s = '0;
      s[3] = ovf_m;
      s[2] = n > 0 || in_frame(e);
      s[1] = n == 0;
      s[0] = n == 8;
      return s;
   endfunction

   // called at a negedge; the access lands on the next rising edge (cyc+1)
   task automatic do_write(input logic [1:0] a, input logic [15:0] d);
      int w, p;
      exp_t e;
      w = cyc + 1;
      wr = 1; addr = a; wdata = d;
      if (a == 2'd0) begin
         if (occ(w) < 8) begin
            p = (w + 1 > last_pop + FRAME) ? w + 1 : last_pop + FRAME;
            e.pop = p; e.data = d[7:0];
            q.push_back(e); hist.push_back(p); last_pop = p;
         end else ovf_m = 1;
      end else if (a == 2'd1 && d[0]) begin
         while (q.size() > 0 && q[$].pop >= w) void'(q.pop_back());
         while (hist.size() > 0 && hist[$] >= w) void'(hist.pop_back());
         last_pop = hist.size() > 0 ? hist[$] : -1000;
      end
      @(negedge clk);
      wr = 0;
   endtask

   task automatic read_stat(input string name);
      rd = 1; addr = 2'd1;
      #1 check(name, rdata, stat_m(cyc));
      ovf_m = 0;
      @(negedge clk);
      rd = 0;
   endtask

   task automatic read_other(input string name, input logic [1:0] a);
      rd = 1; addr = a;
      #1 check(name, rdata, 0);
      @(negedge clk);
      rd = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // line monitor: decodes frames and scores them against the expected queue
   initial begin
      int fcnt = 0;
      bit inf = 0;
      logic [7:0] b = 0;
      forever begin
         @(negedge clk);
         if (!mon_en || !rst_n) inf = 0;
         else if (!inf) begin
            if (line === 1'b0) begin
               inf = 1; fcnt = 0;
               if (q.size() == 0) check("unexpected_frame", 1, 0);
               else check("frame_start_cycle", cyc, q[0].pop + 1);
            end
         end else begin
            fcnt++;
            if (fcnt == 5) check("start_bit", line, 0);
            if (fcnt >= 15 && fcnt <= 85 && fcnt % 10 == 5) b[(fcnt - 15) / 10] = line;
            if (fcnt == 95) begin
               check("stop_bit", line, 1);
               if (q.size() > 0) begin
                  check("frame_data", b, q[0].data);
                  void'(q.pop_front());
               end
            end
            if (fcnt == 99) inf = 0;
         end
      end
   end

   initial begin
      int p0, n;
      idle(3);
      rst_n = 1;
      @(negedge clk);
      check("reset_line", line, 1);
      check("reset_busy", busy, 0);
      check("reset_rdata", rdata, 0);
      read_stat("reset_status");
      // single frame of 0x55
      do_write(2'd0, 16'h1255);
      idle(5);
      check("busy_in_frame", busy, 1);
      read_other("read_data_addr", 2'd0);
      idle(110);
      check("busy_after_frame", busy, 0);
      read_stat("after_single_status");
      // ten back-to-back writes: the tenth is dropped
      repeat (10) do_write(2'd0, 16'($urandom));
      read_stat("overflow_status");
      read_stat("overflow_cleared");
      idle(950);
      read_stat("after_burst_status");
      // random bursts with random gaps
      repeat (4) begin
         n = $urandom_range(1, 12);
         repeat (n) begin
            do_write(2'd0, 16'($urandom));
            idle($urandom_range(0, 3));
         end
         read_stat("random_burst_status");
         idle($urandom_range(50, 400));
      end
      idle(1300);
      read_stat("random_drain_status");
      // flush during the first frame; a control write with bit0 clear does nothing
      repeat (4) do_write(2'd0, 16'($urandom));
      do_write(2'd1, 16'hfffe);
      idle(30);
      do_write(2'd1, 16'h0001);
      idle(10);
      read_stat("flush_status");
      idle(120);
      read_stat("flush_done_status");
      // reserved addresses
      do_write(2'd2, 16'($urandom));
      do_write(2'd3, 16'($urandom));
      read_other("read_addr2", 2'd2);
      read_other("read_addr3", 2'd3);
      read_stat("reserved_status");
      // fill while busy, then push exactly on the stop-to-start pop edge
      do_write(2'd0, 16'($urandom));
      p0 = q[0].pop;
      repeat (8) do_write(2'd0, 16'($urandom));
      read_stat("full_status");
      while (cyc < p0 + FRAME - 1) @(negedge clk);
      do_write(2'd0, 16'($urandom));
      read_stat("push_on_pop_status");
      do_write(2'd0, 16'($urandom));
      read_stat("push_when_full_status");
      idle(1000);
      // reset in the data phase of frame 2 of 3
      repeat (3) do_write(2'd0, 16'($urandom));
      p0 = q[1].pop;
      while (cyc < p0 + 40) @(negedge clk);
      mon_en = 0;
      #2 rst_n = 0;
      #1 check("reset_mid_line", line, 1);
      check("reset_mid_busy", busy, 0);
      q.delete(); hist.delete(); last_pop = -1000; ovf_m = 0;
      idle(2);
      rst_n = 1;
      @(negedge clk);
      mon_en = 1;
      read_stat("post_reset_status");
      check("post_reset_line", line, 1);
      do_write(2'd0, 16'($urandom));
      idle(120);
      check("all_frames_seen", q.size(), 0);
      read_stat("final_status");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
